// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V MEM stage: byte/half/word loads and stores over a req/ack port with
// timeout, stalling upstream while busy and emitting one write-back record per instruction.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic              in_rd_en,
  input  logic              in_wr_en,
  input  logic [2:0]        in_funct3,
  input  logic              in_reg_we,
  input  logic [REG_AW-1:0] in_wb_addr,
  output logic              stall,
  mem_access_unit_if.master mem,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err,
  output logic              bus_err
);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_req_reg, mem_req_next, mem_we_reg, mem_we_next;
  logic [DATA_W-1:0] mem_addr_reg, mem_addr_next, mem_wdata_reg, mem_wdata_next;
  logic [3:0]        mem_wstrb_reg, mem_wstrb_next;
  logic [2:0]        f3_reg, f3_next;
  logic [1:0]        lane_reg, lane_next;
  logic              reg_we_reg, reg_we_next;
  logic [REG_AW-1:0] dest_reg, dest_next;
  logic              wb_valid_reg, wb_valid_next, wb_we_reg, wb_we_next;
  logic [REG_AW-1:0] wb_addr_reg, wb_addr_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic              misalign_reg, misalign_next, bus_err_reg, bus_err_next;

  logic              is_mem, is_byte, is_half, misaligned;
  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata, shifted, load_val;

  // funct3 3/6/7 fall through to word handling
  assign is_mem     = in_rd_en | in_wr_en;
  assign is_byte    = (in_funct3[1:0] == 2'b00);
  assign is_half    = (in_funct3[1:0] == 2'b01);
  assign misaligned = is_half ? in_addr[0] : (!is_byte && (in_addr[1:0] != 2'b00));

  always_comb begin
    strb  = 4'b1111;
    wdata = in_rs2;
    if (is_byte) begin
      strb  = 4'b0001 << in_addr[1:0];
      wdata = DATA_W'({4{in_rs2[7:0]}});
    end else if (is_half) begin
      strb  = in_addr[1] ? 4'b1100 : 4'b0011;
      wdata = DATA_W'({2{in_rs2[15:0]}});
    end
    if (!in_wr_en) strb = 4'b0000;
  end

  // Shifting by the latched lane puts the selected byte/half at bit 0
  assign shifted = mem.mem_rdata >> {lane_reg, 3'b000};

  always_comb begin
    load_val = mem.mem_rdata;
    if (f3_reg[1:0] == 2'b00)
      load_val = f3_reg[2] ? DATA_W'(shifted[7:0])
                           : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
    else if (f3_reg[1:0] == 2'b01)
      load_val = f3_reg[2] ? DATA_W'(shifted[15:0])
                           : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    f3_next        = f3_reg;
    lane_next      = lane_reg;
    reg_we_next    = reg_we_reg;
    dest_next      = dest_reg;
    wb_valid_next  = 1'b0;
    wb_we_next     = wb_we_reg;
    wb_addr_next   = wb_addr_reg;
    wb_data_next   = wb_data_reg;
    misalign_next  = 1'b0;
    bus_err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_next = 1'b1;
            wb_we_next    = in_reg_we;
            wb_addr_next  = in_wb_addr;
            wb_data_next  = in_addr;
          end else if (misaligned) begin
            misalign_next = 1'b1;
            wb_valid_next = 1'b1;
            wb_we_next    = 1'b0;
            wb_addr_next  = in_wb_addr;
            wb_data_next  = '0;
          end else begin
            state_next     = BUSY;
            cnt_next       = '0;
            mem_req_next   = 1'b1;
            mem_we_next    = in_wr_en;
            mem_addr_next  = {in_addr[DATA_W-1:2], 2'b00};
            mem_wdata_next = wdata;
            mem_wstrb_next = strb;
            f3_next        = in_funct3;
            lane_next      = in_addr[1:0];
            reg_we_next    = in_reg_we & ~in_wr_en;
            dest_next      = in_wb_addr;
          end
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          state_next    = IDLE;
          mem_req_next  = 1'b0;
          wb_valid_next = 1'b1;
          wb_we_next    = reg_we_reg;
          wb_addr_next  = dest_reg;
          wb_data_next  = mem_we_reg ? '0 : load_val;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next    = IDLE;
          mem_req_next  = 1'b0;
          bus_err_next  = 1'b1;
          wb_valid_next = 1'b1;
          wb_we_next    = 1'b0;
          wb_addr_next  = dest_reg;
          wb_data_next  = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      f3_reg        <= '0;
      lane_reg      <= '0;
      reg_we_reg    <= 1'b0;
      dest_reg      <= '0;
      wb_valid_reg  <= 1'b0;
      wb_we_reg     <= 1'b0;
      wb_addr_reg   <= '0;
      wb_data_reg   <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      f3_reg        <= f3_next;
      lane_reg      <= lane_next;
      reg_we_reg    <= reg_we_next;
      dest_reg      <= dest_next;
      wb_valid_reg  <= wb_valid_next;
      wb_we_reg     <= wb_we_next;
      wb_addr_reg   <= wb_addr_next;
      wb_data_reg   <= wb_data_next;
      misalign_reg  <= misalign_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign stall         = (state_reg == BUSY);
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_we         = wb_we_reg;
  assign wb_addr       = wb_addr_reg;
  assign wb_data       = wb_data_reg;
  assign misalign_err  = misalign_reg;
  assign bus_err       = bus_err_reg;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access (MEM) stage of the RISC-V pipeline. It sits directly downstream of the ALU/MEM pipeline register and consumes its outputs: effective address, rs2 store data, cache read/write enables, register write enable and write-back address. It performs byte/half/word loads and stores over a request/acknowledge data-memory port, stalling upstream while an access is outstanding. It delivers one registered write-back record per instruction to the MEM/WB stage.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `REG_AW`, 5: register-file address width.
- `TIMEOUT`, 15: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: an instruction is presented by ALU/MEM.
- `in_addr` input DATA_W: ALU result (effective address, or the result for non-memory ops).
- `in_rs2` input DATA_W: store data.
- `in_rd_en` input 1: load.
- `in_wr_en` input 1: store.
- `in_funct3` input 3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `in_reg_we` input 1: register write enable.
- `in_wb_addr` input REG_AW: destination register.
- `stall` output 1: upstream must hold its inputs.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 for a store.
- `mem_addr` output DATA_W: word address, `{in_addr[DATA_W-1:2],2'b00}`.
- `mem_wdata` output DATA_W: lane-replicated store data.
- `mem_wstrb` output 4: byte strobes.
- `mem_ack` input 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input DATA_W: read word.
- `wb_valid` output 1: write-back record valid (1-cycle pulse).
- `wb_we` output 1: register write enable.
- `wb_addr` output REG_AW: destination register.
- `wb_data` output DATA_W: write-back value.
- `misalign_err` output 1: 1-cycle pulse, misaligned access.
- `bus_err` output 1: 1-cycle pulse, timeout.

## Operation
- FSM states:
  - IDLE: `stall`=0. On `in_valid`, the instruction is accepted at the clock edge.
  - BUSY: `stall`=1, `mem_req`=1, address/data/strobes held.
- Non-memory op (`in_rd_en`=`in_wr_en`=0): registers `wb_data`=`in_addr`, `wb_we`=`in_reg_we`, `wb_valid`=1; stays IDLE.
- Both `in_rd_en` and `in_wr_en` asserted: treated as a store.
- Misalignment:
  - H/HU/SH with `addr[0]`=1 is misaligned.
  - W with `addr[1:0]`≠0 is misaligned.
  - A misaligned access issues no request, pulses `misalign_err`, and produces `wb_valid`=1 with `wb_we`=0. State stays IDLE.
- funct3 3, 6 or 7 is treated as W.
- Aligned load/store: latches its fields, drives `mem_req`, and moves to BUSY.
- Store lane mapping:
  - B: `wstrb`=`1<<addr[1:0]`, `wdata`={4{rs2[7:0]}}.
  - H: `wstrb`=`addr[1]` ? 1100 : 0011, `wdata`={2{rs2[15:0]}}.
  - W: `wstrb`=1111, `wdata`=rs2.
  - Loads drive `wstrb`=0000.
- Load extraction: byte at lane `addr[1:0]`, half at lane `addr[1]`. Sign-extend for B/H, zero-extend for BU/HU.
- BUSY with `mem_ack`=1 sampled at an edge:
  - drop `mem_req`;
  - `wb_valid`=1;
  - `wb_we`=`reg_we` for loads, 0 for stores;
  - `wb_data`=extracted load value, or 0 for stores;
  - return to IDLE.
- Timeout: a 4-bit-minimum counter clears on entering BUSY and increments each BUSY cycle without ack. When the count reaches `TIMEOUT`, at that edge:
  - drop `mem_req`;
  - pulse `bus_err`;
  - `wb_valid`=1, `wb_we`=0;
  - return to IDLE.
  - An ack arriving in the same cycle as the timeout wins; no error is raised.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. Asserting `rst_n` mid-access drops `mem_req` asynchronously and discards the in-flight access without any write-back.
- All outputs are registered except `stall`, which decodes to state==BUSY.
- Non-memory op and misaligned access: accepted at edge N, `wb_*` valid in cycle N+1 for exactly one cycle.
- Memory op: accepted at edge N, `mem_req` high from cycle N+1. With ack in cycle N+1+k, `wb_valid` is high in cycle N+2+k and `stall` is high in cycles N+1..N+1+k. A zero-wait memory gives 2-cycle latency and 1 stall cycle.
- During BUSY, `in_*` are not sampled. The next instruction is accepted at the edge that leaves BUSY only if `stall` was low, so acceptance happens no earlier than the first IDLE cycle.
- `wb_valid` pulses are back-to-back for consecutive non-memory ops: one per cycle.

## Test plan
- ALU passthrough: `in_addr`=0x1234, `reg_we`=1, `wb_addr`=7 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_addr`=7, `mem_req`=0.
- LB at 0x103, `mem_rdata`=0x80FF_0000, zero-wait ack → `mem_addr`=0x100, `wstrb`=0, `wb_data`=0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- SH at 0x202, rs2=0xDEAD_BEEF, ack after 3 wait cycles → `wstrb`=1100, `wdata`=0xBEEF_BEEF, `stall` high 4 cycles, `wb_we`=0.
- LW at 0x006 → `misalign_err` pulse, no `mem_req`, `wb_valid`=1 with `wb_we`=0.
- LW, ack never arrives → `mem_req` dropped after 15 cycles, `bus_err` pulse, `wb_we`=0, FSM returns to IDLE. A second run with ack in cycle 15 gives normal completion with no `bus_err`.
- `rst_n` low during BUSY → `mem_req`, `stall` and `wb_valid` go 0 immediately. After release, an ALU op completes normally.
